// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one source register; MEM beats WB, x0 never forwards.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic          wb_we_i,
    output logic [1:0]    fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I pipeline.
// Optional perf counters via `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_AW        = pipeline_hazard_ctrl_pkg::REG_AW,
    parameter int MD_MAX_CYCLES = 40,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_md_op,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic              md_done,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              ifid_clr,
    output logic              idex_clr,
    output logic              exmem_clr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              md_start,
    output logic              md_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  md_cnt
`endif
);

    import pipeline_hazard_ctrl_pkg::*;

    localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);

    hz_state_e       state_q;
    logic            md_start_q;
    logic            md_timeout_q;
    logic [WD_W-1:0] wdog_q;

    logic md_stall;
    logic load_use;
    logic lu_stall;
    logic flush;
    logic ex_reg_write_unused;

    assign ex_reg_write_unused = ex_reg_write;

    hazard_fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .rs_i     (ex_rs1),
        .mem_rd_i (mem_rd),
        .mem_we_i (mem_reg_write),
        .wb_rd_i  (wb_rd),
        .wb_we_i  (wb_reg_write),
        .fwd_o    (fwd_a)
    );

    hazard_fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .rs_i     (ex_rs2),
        .mem_rd_i (mem_rd),
        .mem_we_i (mem_reg_write),
        .wb_rd_i  (wb_rd),
        .wb_we_i  (wb_reg_write),
        .fwd_o    (fwd_b)
    );

    // The md_done cycle itself is released so EX/MEM captures the result.
    assign md_stall = (state_q == RUN) ? ex_md_op : !md_done;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        lu_stall  = 1'b0;
        flush     = 1'b0;
        priority case (1'b1)
            md_stall: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_clr = 1'b1;
            end
            ex_redirect: begin
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
                flush    = 1'b1;
            end
            load_use: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
                lu_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            md_start_q   <= 1'b0;
            md_timeout_q <= 1'b0;
            wdog_q       <= '0;
        end else begin
            md_start_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (ex_md_op) begin
                        state_q    <= MD_WAIT;
                        md_start_q <= 1'b1;
                        wdog_q     <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state_q <= RUN;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        if (wdog_q == WD_W'(MD_MAX_CYCLES - 1)) begin
                            state_q      <= RUN;
                            md_timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign md_start   = md_start_q;
    assign md_timeout = md_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] md_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            md_cnt_q    <= '0;
        end else begin
            if (lu_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if ((state_q == MD_WAIT) && (md_cnt_q != '1)) begin
                md_cnt_q <= md_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign md_cnt    = md_cnt_q;
`else
    localparam int cnt_w_unused = CNT_W;
    logic perf_unused;
    assign perf_unused = lu_stall ^ flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int AW    = 5;
    localparam int MDMAX = 40;
    localparam int CW    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
    logic          ex_md_op, ex_redirect, mem_reg_write, wb_reg_write, md_done;
    logic          pc_en, ifid_en, idex_en, ifid_clr, idex_clr, exmem_clr;
    logic [1:0]    fwd_a, fwd_b;
    logic          md_start, md_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt, md_cnt;
`endif

    pipeline_hazard_ctrl #(.REG_AW(AW), .MD_MAX_CYCLES(MDMAX), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_md_op(ex_md_op), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .md_done(md_done),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .md_start(md_start), .md_timeout(md_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .md_cnt(md_cnt)
`endif
    );

    logic [5:0] ctl;
    assign ctl = {pc_en, ifid_en, idex_en, ifid_clr, idex_clr, exmem_clr};

    int checks = 0;
    int failures = 0;

    // model state
    bit m_wait, m_start, m_to;
    int m_cnt;
    longint m_stall_n, m_flush_n, m_md_n;
    // model predictions
    logic [5:0] e_ctl;
    logic [1:0] e_fa, e_fb;
    bit e_freeze, e_lu, e_fl;

    function automatic logic [1:0] fwd_of(input logic [AW-1:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic predict();
        bit hit1, hit2;
        e_freeze = m_wait ? !md_done : ex_md_op;
        hit1 = id_use_rs1 && id_rs1 == ex_rd;
        hit2 = id_use_rs2 && id_rs2 == ex_rd;
        e_lu = ex_mem_read && ex_rd != 0 && (hit1 || hit2);
        e_fl = 1'b0;
        if (e_freeze) e_ctl = 6'b000001;
        else if (ex_redirect) begin e_ctl = 6'b111110; e_fl = 1'b1; end
        else if (e_lu) e_ctl = 6'b001010;
        else e_ctl = 6'b111000;
        e_fa = fwd_of(ex_rs1);
        e_fb = fwd_of(ex_rs2);
    endtask

    task automatic model_reset();
        m_wait = 0; m_start = 0; m_to = 0; m_cnt = 0;
        m_stall_n = 0; m_flush_n = 0; m_md_n = 0;
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!e_freeze && !e_fl && e_lu) m_stall_n++;
            if (e_fl) m_flush_n++;
            if (m_wait) m_md_n++;
            if (m_wait) begin
                m_start = 0;
                if (md_done) m_wait = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == MDMAX) begin m_wait = 0; m_to = 1; end
                end
            end else begin
                m_start = ex_md_op;
                if (ex_md_op) begin m_wait = 1; m_cnt = 0; end
            end
        end
        #1;
    endtask

    task automatic quiet();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read} = '0;
        {ex_md_op, ex_redirect, mem_reg_write, wb_reg_write, md_done} = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b111000) begin
            failures++; $display("FAIL reset_ctl got=%b exp=111000", ctl);
        end
        checks++;
        if ({md_start, md_timeout, fwd_a, fwd_b} !== 6'b0) begin
            failures++;
            $display("FAIL reset_regs got=%b%b%b%b exp=000000", md_start, md_timeout, fwd_a, fwd_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        quiet();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
        id_rs1 = 5; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
        @(negedge clk); predict();
        checks++;
        if (ctl !== 6'b001010 || ctl !== e_ctl) begin
            failures++; $display("FAIL load_use_stall got=%b exp=001010", ctl);
        end
        tick();
        quiet();
        mem_rd = 5; mem_reg_write = 1;
        id_rs1 = 5; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b111000) begin
            failures++; $display("FAIL load_use_release got=%b exp=111000", ctl);
        end
        tick();
        quiet();
        wb_rd = 5; wb_reg_write = 1; ex_rs1 = 5; ex_rs2 = 7;
        @(negedge clk);
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL load_use_fwd got=%b/%b exp=01/00", fwd_a, fwd_b);
        end
        tick();
    endtask

    task automatic test_forward();
        quiet();
        mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
        ex_rs1 = 5; ex_rs2 = 5;
        @(negedge clk);
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            failures++; $display("FAIL fwd_mem_prio got=%b/%b exp=10/10", fwd_a, fwd_b);
        end
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        @(negedge clk);
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", fwd_a, fwd_b);
        end
        mem_rd = 9; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 9; mem_reg_write = 0;
        @(negedge clk);
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL fwd_wb_only got=%b/%b exp=01/00", fwd_a, fwd_b);
        end
        tick();
    endtask

    task automatic test_redirect();
        quiet();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4;
        id_rs2 = 4; id_use_rs2 = 1; ex_redirect = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b111110) begin
            failures++; $display("FAIL redirect_over_lu got=%b exp=111110", ctl);
        end
        tick();
    endtask

    task automatic test_md_done();
        int starts = 0;
        quiet();
        ex_md_op = 1;
        for (int i = 0; i < 7; i++) begin
            md_done = (i == 6);
            @(negedge clk);
            starts += int'(md_start);
            checks++;
            if (ctl !== ((i == 6) ? 6'b111000 : 6'b000001)) begin
                failures++; $display("FAIL md_freeze cyc=%0d got=%b", i, ctl);
            end
            tick();
        end
        quiet();
        @(negedge clk);
        starts += int'(md_start);
        checks++;
        if (ctl !== 6'b111000 || starts != 1 || m_wait) begin
            failures++; $display("FAIL md_release got=%b starts=%0d exp=111000/1", ctl, starts);
        end
        tick();
    endtask

    task automatic test_md_timeout();
        quiet();
        ex_md_op = 1;
        tick();
        ex_md_op = 0;
        for (int i = 0; i < MDMAX; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 6'b000001 || md_timeout !== 1'b0) begin
                failures++; $display("FAIL md_wait cyc=%0d got=%b to=%b", i, ctl, md_timeout);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (md_timeout !== 1'b1 || ctl !== 6'b111000) begin
            failures++; $display("FAIL md_timeout got=%b ctl=%b exp=1/111000", md_timeout, ctl);
        end
        ex_md_op = 1;
        tick();
        ex_md_op = 0;
        tick(); tick();
        #2 rst_n = 1'b0;
        model_reset();
        md_done = 1;
        #1;
        checks++;
        if (ctl !== 6'b111000 || md_start !== 1'b0 || md_timeout !== 1'b0) begin
            failures++; $display("FAIL reset_mid_wait ctl=%b st=%b to=%b", ctl, md_start, md_timeout);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b111000) begin
            failures++; $display("FAIL done_ignored got=%b exp=111000", ctl);
        end
        tick();
        md_done = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            id_rs1 = AW'($urandom_range(0, 3));
            id_rs2 = AW'($urandom_range(0, 3));
            ex_rs1 = AW'($urandom_range(0, 3));
            ex_rs2 = AW'($urandom_range(0, 3));
            ex_rd  = AW'($urandom_range(0, 3));
            mem_rd = AW'($urandom_range(0, 3));
            wb_rd  = AW'($urandom_range(0, 3));
            {id_use_rs1, id_use_rs2, ex_reg_write} = 3'($urandom);
            {mem_reg_write, wb_reg_write} = 2'($urandom);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            ex_md_op    = ($urandom_range(0, 24) == 0);
            md_done     = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            predict();
            checks++;
            if (ctl !== e_ctl || fwd_a !== e_fa || fwd_b !== e_fb) begin
                failures++;
                $display("FAIL rand_comb n=%0d got=%b/%b/%b exp=%b/%b/%b",
                         n, ctl, fwd_a, fwd_b, e_ctl, e_fa, e_fb);
            end
            checks++;
            if (md_start !== m_start || md_timeout !== m_to) begin
                failures++;
                $display("FAIL rand_regs n=%0d got=%b/%b exp=%b/%b",
                         n, md_start, md_timeout, m_start, m_to);
            end
            tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        checks++;
        if (longint'(stall_cnt) != m_stall_n || longint'(flush_cnt) != m_flush_n
            || longint'(md_cnt) != m_md_n) begin
            failures++;
            $display("FAIL perf_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     stall_cnt, flush_cnt, md_cnt, m_stall_n, m_flush_n, m_md_n);
        end
`endif
        quiet();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_md_done();
        test_md_timeout();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
